// File: rtl/bram_sd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_sd_seq_pkg
// Purpose  : Shared types and constants for the backup-RAM SD sector sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package bram_sd_seq_pkg;

  localparam int c_SLOT_W          = 2;
  localparam int c_DEFAULT_SECTORS = 128;
  localparam int c_DEFAULT_TIMEOUT = 16777216;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bram_sd_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : bram_sd_seq_timer
// Purpose  : Acknowledge-wait counter; flags expiry after TIMEOUT-1 counts.
// Revision : 1.0 - initial release
// ============================================================================
module bram_sd_seq_timer
  import bram_sd_seq_pkg::*;
#(
  parameter int TIMEOUT = c_DEFAULT_TIMEOUT
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                 c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT - 1);

  logic [c_CNT_W-1:0] r_cnt;

  // Count cycles spent waiting for an acknowledge; clear has priority.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign expired = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/bram_sd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bram_sd_seq
// Purpose  : Streams one save slot of backup RAM to/from SD, one sector per
//            sd_ack handshake, with dirty tracking and request timeout.
// Revision : 1.0 - initial release
// ============================================================================
module bram_sd_seq
  import bram_sd_seq_pkg::*;
#(
  parameter int SECTORS = c_DEFAULT_SECTORS,
  parameter int TIMEOUT = c_DEFAULT_TIMEOUT
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                bk_ena,
  input  logic                bk_load,
  input  logic                bk_save,
  input  logic [c_SLOT_W-1:0] slot,
  input  logic                bram_we,
  input  logic                sd_ack,
  output logic [31:0]         sd_lba,
  output logic                sd_rd,
  output logic                sd_wr,
  output logic                bk_loading,
  output logic                busy,
  output logic                dirty,
  output logic                done,
  output logic                err
);

  localparam int c_SEC_W = (SECTORS > 2) ? $clog2(SECTORS) : 1;
  localparam int c_PAD_W = 32 - c_SLOT_W - c_SEC_W;

  state_t r_state;
  logic   r_load_q;
  logic   r_save_q;
  logic   r_ack_q;

  logic        w_load_rise;
  logic        w_save_rise;
  logic        w_ack_rise;
  logic        w_ack_fall;
  logic        w_start;
  logic        w_last;
  logic        w_seq_done;
  logic        w_next_sector;
  logic        w_expired;
  logic [31:0] w_start_lba;

  assign w_load_rise   = bk_load & ~r_load_q;
  assign w_save_rise   = bk_save & ~r_save_q;
  assign w_ack_rise    = sd_ack & ~r_ack_q;
  assign w_ack_fall    = ~sd_ack & r_ack_q;
  assign w_start       = (r_state == ST_IDLE) && bk_ena && (w_load_rise || w_save_rise);
  assign w_last        = &sd_lba[c_SEC_W-1:0];
  assign w_seq_done    = (r_state == ST_XFER) && w_ack_fall && w_last;
  assign w_next_sector = (r_state == ST_XFER) && w_ack_fall && !w_last;
  assign w_start_lba   = {{c_PAD_W{1'b0}}, slot, {c_SEC_W{1'b0}}};

  // Edge-detect history for the request levels and the acknowledge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_load_q <= 1'b0;
      r_save_q <= 1'b0;
      r_ack_q  <= 1'b0;
    end else begin
      r_load_q <= bk_load;
      r_save_q <= bk_save;
      r_ack_q  <= sd_ack;
    end
  end

  bram_sd_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (w_start || w_next_sector),
    .enable  (r_state == ST_REQ),
    .expired (w_expired)
  );

  // Sector sequencer: issue a request, wait for ack high, then ack low.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      bk_loading <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Load wins over a simultaneous save edge.
          if (w_start) begin
            sd_lba     <= w_start_lba;
            sd_rd      <= w_load_rise;
            sd_wr      <= ~w_load_rise;
            bk_loading <= w_load_rise;
            busy       <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_ack_rise) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            r_state <= ST_XFER;
          end else if (w_expired) begin
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            busy       <= 1'b0;
            bk_loading <= 1'b0;
            err        <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (w_seq_done) begin
            busy       <= 1'b0;
            bk_loading <= 1'b0;
            done       <= 1'b1;
            r_state    <= ST_IDLE;
          end else if (w_next_sector) begin
            // The request direction is implied by bk_loading for the whole run.
            sd_lba  <= sd_lba + 32'd1;
            sd_rd   <= bk_loading;
            sd_wr   <= ~bk_loading;
            r_state <= ST_REQ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Dirty flag: core writes outside a load set it; a completed run clears it.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dirty <= 1'b0;
    end else if (bram_we && !bk_loading) begin
      dirty <= 1'b1;
    end else if (w_seq_done) begin
      dirty <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_sd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_sd_seq
// Purpose  : Self-checking bench for bram_sd_seq with a randomised SD host.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_sd_seq;

  localparam int SECTORS = 128;
  localparam int TIMEOUT = 16;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        bk_ena  = 1'b0;
  logic        bk_load = 1'b0;
  logic        bk_save = 1'b0;
  logic [1:0]  slot    = 2'd0;
  logic        bram_we = 1'b0;
  logic        sd_ack  = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        bk_loading;
  logic        busy;
  logic        dirty;
  logic        done;
  logic        err;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  bit model_dirty = 1'b0;

  bram_sd_seq #(
    .SECTORS (SECTORS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bk_ena     (bk_ena),
    .bk_load    (bk_load),
    .bk_save    (bk_save),
    .slot       (slot),
    .bram_we    (bram_we),
    .sd_ack     (sd_ack),
    .sd_lba     (sd_lba),
    .sd_rd      (sd_rd),
    .sd_wr      (sd_wr),
    .bk_loading (bk_loading),
    .busy       (busy),
    .dirty      (dirty),
    .done       (done),
    .err        (err)
  );

  always #5 clk_sys = ~clk_sys;

  // Advance to the next falling edge and tally completion/abort pulses.
  task automatic tick();
    @(negedge clk_sys);
    if (done) done_cnt++;
    if (err)  err_cnt++;
  endtask

  // Acts as the SD host for nsec sectors; expected address is base+k.
  task automatic serve(input bit exp_rd, input int base, input int nsec,
                       input bit rnd, input bit we_last, input int poke_at);
    int n, d, h, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    for (int k = 0; k < nsec; k++) begin
      n = 0;
      while (!(sd_rd || sd_wr) && n < 40) begin
        tick();
        n++;
      end
      checks++;
      if (!(sd_rd || sd_wr)) begin
        errors++;
        $display("FAIL req_wait k=%0d: no request within 40 cycles", k);
        return;
      end
      checks++;
      if (sd_lba !== 32'(base + k)) begin
        errors++;
        $display("FAIL lba k=%0d: got %0d expected %0d", k, sd_lba, base + k);
      end
      checks++;
      if (sd_rd !== exp_rd || sd_wr !== !exp_rd) begin
        errors++;
        $display("FAIL dir k=%0d: got rd=%b wr=%b expected rd=%b wr=%b", k, sd_rd, sd_wr, exp_rd, !exp_rd);
      end
      checks++;
      if (bk_loading !== exp_rd || busy !== 1'b1) begin
        errors++;
        $display("FAIL status k=%0d: got loading=%b busy=%b expected loading=%b busy=1", k, bk_loading, busy, exp_rd);
      end
      checks++;
      if (dirty !== model_dirty) begin
        errors++;
        $display("FAIL dirty_mid k=%0d: got %b expected %b", k, dirty, model_dirty);
      end
      if (poke_at >= 0 && k == 0) bk_save = 1'b0;
      if (k == poke_at) bk_save = 1'b1;
      slot = 2'($urandom_range(0, 3));
      d = rnd ? int'($urandom_range(1, 10)) : 3;
      h = rnd ? int'($urandom_range(1, 6)) : 4;
      repeat (d) tick();
      sd_ack = 1'b1;
      repeat (h) begin
        bram_we = exp_rd ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      bram_we = we_last && (k == SECTORS - 1);
      sd_ack  = 1'b0;
    end
    if (nsec == SECTORS) begin
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || bk_loading !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
        errors++;
        $display("FAIL end_state: got done=%b busy=%b loading=%b rd=%b wr=%b expected 1 0 0 0 0",
                 done, busy, bk_loading, sd_rd, sd_wr);
      end
      bram_we     = 1'b0;
      model_dirty = we_last;
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_width: got done=%b expected 0", done);
      end
      checks++;
      if (done_cnt - d0 != 1 || err_cnt != e0) begin
        errors++;
        $display("FAIL pulse_count: got done=%0d err=%0d expected done=1 err=0", done_cnt - d0, err_cnt - e0);
      end
      checks++;
      if (dirty !== model_dirty) begin
        errors++;
        $display("FAIL dirty_end: got %b expected %b", dirty, model_dirty);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({sd_lba, sd_rd, sd_wr, bk_loading, busy, dirty, done, err} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: got lba=%0d rd=%b wr=%b ld=%b busy=%b dirty=%b done=%b err=%b expected all 0",
               sd_lba, sd_rd, sd_wr, bk_loading, busy, dirty, done, err);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_enable_off();
    bk_ena  = 1'b0;
    bk_load = 1'b1;
    repeat (10) tick();
    checks++;
    if (busy !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
      errors++;
      $display("FAIL ena_off: got busy=%b rd=%b wr=%b expected 0 0 0", busy, sd_rd, sd_wr);
    end
    bk_ena = 1'b1;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || sd_rd !== 1'b0) begin
      errors++;
      $display("FAIL ena_not_queued: got busy=%b rd=%b expected 0 0", busy, sd_rd);
    end
    bk_load = 1'b0;
    tick();
  endtask

  task automatic test_load();
    bk_ena = 1'b1;
    slot   = 2'd2;
    tick();
    bk_load = 1'b1;
    serve(1'b1, 2 * SECTORS, SECTORS, 1'b0, 1'b0, -1);
    bk_load = 1'b0;
    tick();
  endtask

  task automatic test_save_dirty();
    bram_we = 1'b1;
    tick();
    bram_we = 1'b0;
    tick();
    model_dirty = 1'b1;
    checks++;
    if (dirty !== 1'b1) begin
      errors++;
      $display("FAIL dirty_set: got %b expected 1", dirty);
    end
    slot = 2'd1;
    bk_save = 1'b1;
    serve(1'b0, SECTORS, SECTORS, 1'b1, 1'b0, -1);
    bk_save = 1'b0;
    slot = 2'd1;
    tick();
    bk_save = 1'b1;
    serve(1'b0, SECTORS, SECTORS, 1'b1, 1'b1, -1);
    bk_save = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    logic [1:0] s;
    s    = 2'($urandom_range(0, 3));
    slot = s;
    tick();
    bk_load = 1'b1;
    bk_save = 1'b1;
    serve(1'b1, int'(s) * SECTORS, SECTORS, 1'b1, 1'b0, 10);
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || sd_wr !== 1'b0) begin
      errors++;
      $display("FAIL save_not_queued: got busy=%b wr=%b expected 0 0", busy, sd_wr);
    end
    bk_load = 1'b0;
    bk_save = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n, cnt, d0, e0;
    bram_we = 1'b1;
    tick();
    bram_we = 1'b0;
    model_dirty = 1'b1;
    d0 = done_cnt;
    e0 = err_cnt;
    bk_save = 1'b1;
    n = 0;
    while (!sd_wr && n < 10) begin
      tick();
      n++;
    end
    cnt = 0;
    while (sd_wr && cnt < 40) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_len: got %0d request cycles expected %0d", cnt, TIMEOUT);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0 || bk_loading !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: got err=%b busy=%b rd=%b wr=%b ld=%b expected 1 0 0 0 0",
               err, busy, sd_rd, sd_wr, bk_loading);
    end
    tick();
    checks++;
    if (err !== 1'b0 || err_cnt - e0 != 1 || done_cnt != d0) begin
      errors++;
      $display("FAIL timeout_pulses: got err=%b errs=%0d dones=%0d expected 0 1 0", err, err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (dirty !== model_dirty) begin
      errors++;
      $display("FAIL timeout_dirty: got %b expected %b", dirty, model_dirty);
    end
    bk_save = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    slot = 2'd3;
    tick();
    bk_load = 1'b1;
    serve(1'b1, 3 * SECTORS, 40, 1'b1, 1'b0, -1);
    tick();
    checks++;
    if (sd_rd !== 1'b1 || sd_lba !== 32'(3 * SECTORS + 40)) begin
      errors++;
      $display("FAIL pre_reset: got rd=%b lba=%0d expected 1 %0d", sd_rd, sd_lba, 3 * SECTORS + 40);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({sd_lba, sd_rd, sd_wr, bk_loading, busy, dirty, done, err} !== 39'd0) begin
      errors++;
      $display("FAIL async_reset: got lba=%0d rd=%b wr=%b ld=%b busy=%b dirty=%b expected all 0",
               sd_lba, sd_rd, sd_wr, bk_loading, busy, dirty);
    end
    model_dirty = 1'b0;
    slot = 2'd3;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (sd_rd !== 1'b1 || sd_lba !== 32'(3 * SECTORS) || bk_loading !== 1'b1) begin
      errors++;
      $display("FAIL restart: got rd=%b lba=%0d ld=%b expected 1 %0d 1", sd_rd, sd_lba, bk_loading, 3 * SECTORS);
    end
    serve(1'b1, 3 * SECTORS, SECTORS, 1'b1, 1'b0, -1);
    bk_load = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_enable_off();
    test_load();
    test_save_dirty();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
